// File: rtl/calendar_date_counter.sv
// Calendar date counter: day/month/year with a day-of-year value that is
// recomputed over several cycles (one month per cycle) after each load.
module calendar_date_counter #(
    parameter int RESET_YEAR = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        load,
    input  logic [5:0]  loadDay,
    input  logic [3:0]  loadMonth,
    input  logic [10:0] loadYear,
    output logic [5:0]  dayOfMonth,
    output logic [3:0]  month,
    output logic [10:0] year,
    output logic [8:0]  dayOfYear,
    output logic        leap,
    output logic        valid,
    output logic        busy,
    output logic        loadErr,
    output logic        overrun
);

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_day;
    logic [3:0]  r_month;
    logic [10:0] r_year;
    logic [8:0]  r_doy;
    logic [3:0]  r_idx;
    logic [8:0]  r_acc;
    logic        r_loadErr;
    logic        r_overrun;

    logic        w_leap;
    logic        w_load_ok;
    logic        w_accept;
    logic        w_calc_done;
    logic [5:0]  w_cur_len;
    logic [5:0]  w_idx_len;

    // Leap rule is divisibility by 4 only, so the low two year bits suffice.
    function automatic logic [5:0] f_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                   f_len = lp ? 6'd29 : 6'd28;
            4'd4, 4'd6, 4'd9, 4'd11: f_len = 6'd30;
            default:                f_len = 6'd31;
        endcase
    endfunction

    assign w_leap      = (r_year[1:0] == 2'b00);
    assign w_cur_len   = f_len(r_month, w_leap);
    assign w_idx_len   = f_len(r_idx, w_leap);
    assign w_load_ok   = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) && (loadDay >= 6'd1) &&
                         (loadDay <= f_len(loadMonth, loadYear[1:0] == 2'b00));
    assign w_accept    = (r_state == IDLE) && load && w_load_ok;
    assign w_calc_done = (r_state == CALC) && (r_idx == r_month);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = CALC;
            CALC: if (r_idx == r_month) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == CALC);
        valid = (r_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_day     <= 6'd1;
            r_month   <= 4'd1;
            r_year    <= 11'(RESET_YEAR);
            r_doy     <= 9'd1;
            r_idx     <= 4'd1;
            r_acc     <= 9'd0;
            r_loadErr <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Any load not accepted (bad date, or arriving mid-CALC) is flagged.
            r_loadErr <= load && !w_accept;
            r_overrun <= advance && ((r_state == CALC) || load);
            if (w_accept) begin
                r_day   <= loadDay;
                r_month <= loadMonth;
                r_year  <= loadYear;
                r_idx   <= 4'd1;
                r_acc   <= {3'd0, loadDay};
            end else if (r_state == CALC) begin
                if (w_calc_done) begin
                    r_doy <= r_acc;
                end else begin
                    r_acc <= r_acc + {3'd0, w_idx_len};
                    r_idx <= r_idx + 4'd1;
                end
            end else if (advance && !load) begin
                if (r_day < w_cur_len) begin
                    r_day <= r_day + 6'd1;
                    r_doy <= r_doy + 9'd1;
                end else if (r_month < 4'd12) begin
                    r_day   <= 6'd1;
                    r_month <= r_month + 4'd1;
                    r_doy   <= r_doy + 9'd1;
                end else begin
                    r_day   <= 6'd1;
                    r_month <= 4'd1;
                    r_year  <= r_year + 11'd1;
                    r_doy   <= 9'd1;
                end
            end
        end
    end

    assign dayOfMonth = r_day;
    assign month      = r_month;
    assign year       = r_year;
    assign dayOfYear  = r_doy;
    assign leap       = w_leap;
    assign loadErr    = r_loadErr;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed test of calendar_date_counter: reset, loads, CALC latency,
// advance rollovers, rejected loads, overrun and reset mid-CALC.
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        reset, advance, load;
    logic [5:0]  loadDay;
    logic [3:0]  loadMonth;
    logic [10:0] loadYear;
    logic [5:0]  dayOfMonth;
    logic [3:0]  month;
    logic [10:0] year;
    logic [8:0]  dayOfYear;
    logic        leap, valid, busy, loadErr, overrun;

    int nchk = 0;
    int nerr = 0;

    calendar_date_counter #(.RESET_YEAR(2000)) dut (
        .clk(clk), .reset(reset), .advance(advance), .load(load),
        .loadDay(loadDay), .loadMonth(loadMonth), .loadYear(loadYear),
        .dayOfMonth(dayOfMonth), .month(month), .year(year),
        .dayOfYear(dayOfYear), .leap(leap), .valid(valid), .busy(busy),
        .loadErr(loadErr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int d, input int m, input int y, input int doy);
        chk({tag, ".day"}, dayOfMonth, d);
        chk({tag, ".month"}, month, m);
        chk({tag, ".year"}, year, y);
        chk({tag, ".doy"}, dayOfYear, doy);
    endtask

    task automatic do_load(input int d, input int m, input int y, input logic adv);
        load = 1'b1; loadDay = 6'(d); loadMonth = 4'(m); loadYear = 11'(y); advance = adv;
        step();
        load = 1'b0; advance = 1'b0;
    endtask

    task automatic do_adv();
        advance = 1'b1;
        step();
        advance = 1'b0;
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0; load = 1'b0;
        loadDay = '0; loadMonth = '0; loadYear = '0;
        step();
        reset = 1'b0;
        chk_date("reset", 1, 1, 2000, 1);
        chk("reset.leap", leap, 1);
        chk("reset.valid", valid, 1);
        chk("reset.busy", busy, 0);
        chk("reset.loadErr", loadErr, 0);
        chk("reset.overrun", overrun, 0);

        // 31/12/2023: busy for 12 cycles, then day 365
        do_load(31, 12, 2023, 1'b0);
        chk("dec.busy0", busy, 1);
        chk("dec.valid0", valid, 0);
        chk("dec.day_loaded", dayOfMonth, 31);
        for (int i = 0; i < 11; i++) begin
            step();
            chk("dec.busy_hold", busy, 1);
        end
        step();
        chk("dec.busy_end", busy, 0);
        chk("dec.valid_end", valid, 1);
        chk_date("dec", 31, 12, 2023, 365);
        chk("dec.leap", leap, 0);
        do_adv();
        chk_date("newyear", 1, 1, 2024, 1);
        chk("newyear.leap", leap, 1);

        // 28/2/2024 -> 59, then 29/2 (60), 1/3 (61)
        do_load(28, 2, 2024, 1'b0);
        step();
        chk("feb.busy1", busy, 1);
        step();
        chk("feb.busy2", busy, 0);
        chk_date("feb", 28, 2, 2024, 59);
        do_adv();
        chk_date("feb29", 29, 2, 2024, 60);
        do_adv();
        chk_date("mar1", 1, 3, 2024, 61);

        // Rejected loads: no state change, single-cycle loadErr
        do_load(29, 2, 2023, 1'b0);
        chk("rej29.loadErr", loadErr, 1);
        chk("rej29.busy", busy, 0);
        chk_date("rej29", 1, 3, 2024, 61);
        step();
        chk("rej29.loadErr_clr", loadErr, 0);
        do_load(0, 5, 2024, 1'b0);
        chk("rejd0.loadErr", loadErr, 1);
        chk_date("rejd0", 1, 3, 2024, 61);
        step();
        chk("rejd0.loadErr_clr", loadErr, 0);
        do_load(10, 13, 2024, 1'b0);
        chk("rejm13.loadErr", loadErr, 1);
        chk_date("rejm13", 1, 3, 2024, 61);
        step();
        chk("rejm13.loadErr_clr", loadErr, 0);

        // Load during CALC is ignored: 15/3/2024 -> 75
        do_load(15, 3, 2024, 1'b0);
        do_load(1, 1, 2000, 1'b0);
        chk("calcld.loadErr", loadErr, 1);
        chk("calcld.busy", busy, 1);
        chk("calcld.day", dayOfMonth, 15);
        step();
        chk("calcld.loadErr_clr", loadErr, 0);
        chk("calcld.busy2", busy, 1);
        step();
        chk("calcld.busy_end", busy, 0);
        chk_date("calcld", 15, 3, 2024, 75);

        // Load with advance: load wins, overrun pulses
        do_load(10, 1, 2024, 1'b1);
        chk("ldadv.overrun", overrun, 1);
        chk("ldadv.loadErr", loadErr, 0);
        chk("ldadv.busy", busy, 1);
        step();
        chk("ldadv.overrun_clr", overrun, 0);
        chk_date("ldadv", 10, 1, 2024, 10);

        // Advance during CALC: 5/4/2024 -> 96, date unchanged
        do_load(5, 4, 2024, 1'b0);
        do_adv();
        chk("calcadv.overrun", overrun, 1);
        chk("calcadv.busy", busy, 1);
        chk("calcadv.day", dayOfMonth, 5);
        step();
        chk("calcadv.overrun_clr", overrun, 0);
        step();
        step();
        chk("calcadv.busy_end", busy, 0);
        chk_date("calcadv", 5, 4, 2024, 96);

        // Year wrap 2047 -> 0
        do_load(31, 12, 2047, 1'b0);
        for (int i = 0; i < 12; i++) step();
        chk("wrap.valid", valid, 1);
        chk_date("wrap_pre", 31, 12, 2047, 365);
        do_adv();
        chk_date("wrap", 1, 1, 0, 1);
        chk("wrap.leap", leap, 1);

        // Reset mid-CALC
        do_load(1, 6, 2001, 1'b0);
        step();
        chk("midrst.busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_date("midrst", 1, 1, 2000, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.valid", valid, 1);
        chk("midrst.leap", leap, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/calendar_date_counter.md
CALENDAR_DATE_COUNTER -- requirements
Module: calendar_date_counter

Interface
REQ-001 SHALL have parameter RESET_YEAR, default 2000, meaning the year loaded on reset (0..2047).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: advance  input  1  one-day tick request.
REQ-006 SHALL have port: load  input  1  load request for loadDay/loadMonth/loadYear.
REQ-007 SHALL have port: loadDay  input  6  day of month to load (1..31).
REQ-008 SHALL have port: loadMonth  input  4  month to load (1..12).
REQ-009 SHALL have port: loadYear  input  11  year to load (0..2047).
REQ-010 SHALL have port: dayOfMonth  output  6  current day (1..31).
REQ-011 SHALL have port: month  output  4  current month (1..12).
REQ-012 SHALL have port: year  output  11  current year.
REQ-013 SHALL have port: dayOfYear  output  9  day of year (1..366), registered.
REQ-014 SHALL have port: leap  output  1  high when year[1:0]==0; combinational from the year register.
REQ-015 SHALL have port: valid  output  1  high when dayOfYear matches the current date.
REQ-016 SHALL have port: busy  output  1  high while in state CALC.
REQ-017 SHALL have port: loadErr  output  1  one-cycle pulse; load rejected.
REQ-018 SHALL have port: overrun  output  1  one-cycle pulse; advance dropped.

Function
REQ-019 SHALL compute month length as 31 (months 1,3,5,7,8,10,12), 30 (months 4,6,9,11), or 29 for February when leap, else 28; leap rule is divisibility by 4 only, with no divide operator.
REQ-020 SHALL have two states, IDLE and CALC; busy=1 exactly in CALC; valid=0 in CALC and 1 in IDLE.
REQ-021 In IDLE, SHALL accept a load only if 1<=loadMonth<=12 and 1<=loadDay<=length(loadMonth, loadYear[1:0]==0).
- Accepted load: date registers take the load values at the sampling edge; state goes to CALC with month index idx=1 and accumulator acc=loadDay.
- Rejected load: date, dayOfYear and state unchanged; loadErr=1 for exactly the next cycle.
REQ-022 In CALC, SHALL do one of the following each cycle:
- idx==month: dayOfYear<=acc and return to IDLE.
- Otherwise: acc<=acc+length(idx), idx<=idx+1.
- Load-to-valid latency SHALL be exactly month cycles after the accepting edge (January = 1).
REQ-023 A load in CALC SHALL be ignored and SHALL pulse loadErr.
REQ-024 In IDLE with advance=1 and load=0, SHALL do one of the following:
- dayOfMonth<length: dayOfMonth+1 and dayOfYear+1.
- dayOfMonth==length and month<12: dayOfMonth=1, month+1, dayOfYear+1.
- 31 Dec: date 1 Jan, year+1, dayOfYear=1.
REQ-025 Year SHALL wrap 2047 -> 0 on rollover.
REQ-026 Advance SHALL be single-cycle (no CALC).
REQ-027 When load and advance are both high in IDLE, load SHALL take priority; advance is dropped and overrun pulses.
REQ-028 Advance in CALC SHALL be dropped and SHALL pulse overrun, leaving state unchanged.
REQ-029 The 9-bit accumulator SHALL never exceed 366 for valid loads; no saturation logic is required.

Reset
REQ-030 On reset=1 at a rising edge, regardless of state (including mid-CALC), SHALL set dayOfMonth=1, month=1, year=RESET_YEAR, dayOfYear=1, state IDLE, valid=1, busy=0, loadErr=0, overrun=0.
REQ-031 Reset SHALL take priority over load and advance.

Verification
REQ-032 Reset with RESET_YEAR=2000 -> 1/1/2000, dayOfYear=1, leap=1, valid=1, busy=0.
REQ-033 Load 31/12/2023 -> busy for 12 cycles, then dayOfYear=365; advance -> 1/1/2024, dayOfYear=1, leap=1.
REQ-034 Load 28/2/2024 -> dayOfYear=59 after 2 cycles; advance -> 29/2 (60); advance -> 1/3 (61).
REQ-035 Load 29/2/2023, load day 0, and load month 13 -> each gives a one-cycle loadErr with no state change; load during CALC -> loadErr, CALC result unaffected.
REQ-036 Load with advance in the same cycle -> load wins, one-cycle overrun pulse; advance during CALC -> overrun pulse, date unchanged.
REQ-037 Load 31/12/2047 and advance -> 1/1/0, leap=1, dayOfYear=1; reset asserted mid-CALC -> reset values on the next cycle.
